fp_mul_norm_round: RTL
======================

FP_MUL_NORM_ROUND -- requirements
Module: fp_mul_norm_round

Interface
REQ-001 Parameter FLUSH_SUBNORMAL, default 1, meaning: results with biased exponent <= 0 are flushed to signed zero.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 in_valid  input  1  upstream product and operands valid.
REQ-005 in_ready  output  1  block accepts the input this cycle.
REQ-006 prod  input  48  unsigned mantissa product from the Booth multiplier, hidden bits included (bit 47 or bit 46 is the leading one).
REQ-007 exp_sum  input  10  signed biased exponent, ea+eb-127.
REQ-008 sign_in  input  1  sa XOR sb.
REQ-009 spec_in  input  3  {is_nan, is_inf, is_zero} operand class, precomputed upstream.
REQ-010 out_valid  output  1  result valid.
REQ-011 out_ready  input  1  downstream accepts the result.
REQ-012 result  output  32  IEEE-754 single-precision product.
REQ-013 flags  output  3  {overflow, underflow, inexact}.

Function
REQ-014 The block SHALL be a 2-stage pipeline: S1 normalize, S2 round/pack; latency 2 cycles from accept to out_valid with no stalls.
REQ-015 Input accept SHALL occur when in_valid && in_ready; advance = !out_valid || out_ready; in_ready = advance.
REQ-016 When advance = 0, both stages SHALL hold contents unchanged; result and flags SHALL be stable while out_valid && !out_ready.
REQ-017 S1 normalization, prod[47]=1: mant = prod[46:24], guard = prod[23], sticky = OR prod[22:0], exp = exp_sum+1.
REQ-018 S1 normalization, prod[47]=0: mant = prod[45:23], guard = prod[22], sticky = OR prod[21:0], exp = exp_sum.
REQ-019 S2 SHALL round to nearest even: increment when guard && (sticky || mant[0]).
REQ-020 A mantissa carry-out on rounding SHALL produce mant = 0 and exp+1.
REQ-021 inexact SHALL be guard || sticky for finite, non-special results.
REQ-022 Final exp >= 255 SHALL give {sign,8'hFF,23'd0} with overflow=1 and inexact=1.
REQ-023 Final exp <= 0 with FLUSH_SUBNORMAL=1 SHALL give {sign,31'd0} with underflow=1 and inexact=1.
REQ-024 Special priority SHALL be: NaN, or Inf with zero, gives 32'h7FC00000 with flags 0; else Inf gives signed infinity with flags 0; else zero gives signed zero with flags 0.
REQ-025 A bubble (stage empty) SHALL propagate as out_valid=0; stage valid bits SHALL move only on advance.
REQ-026 Simultaneous accept and output handshake in one cycle SHALL sustain full throughput of 1 result/cycle.

Reset
REQ-027 On rst: out_valid=0, S1 valid=0, result=32'd0, flags=3'd0; in_ready=1 in the first cycle after reset.
REQ-028 Reset mid-operation SHALL discard in-flight data; no result from before reset SHALL appear afterwards.

Structure
REQ-029 A shared package SHALL hold: the bias constant 127, EXP_MAX 255, QNAN 32'h7FC00000, the spec_in bit indices, and the flags bit indices.
REQ-030 One sub-module, fp_round_rne, SHALL implement REQ-019..REQ-023 combinationally.
REQ-031 The normalize stage SHALL be inline.

Verification
REQ-032 prod=48'h400000000000, exp_sum=127, sign=0 -> after 2 cycles result=32'h3F800000, flags=0.
REQ-033 prod=48'h900000000000 (1.5*1.5), exp_sum=127 -> result=32'h40100000, flags=0.
REQ-034 Round tie cases:
- prod=48'h400000400000 -> result 32'h3F800000, inexact=1 (tie, even).
- prod=48'h400000C00000 -> result 32'h3F800002, inexact=1.
REQ-035 Exponent limits:
- exp_sum=254, prod=48'h800000000000 -> 32'h7F800000, overflow=1.
- exp_sum=-5, sign=1 -> 32'h80000000, underflow=1.
REQ-036 Backpressure and reset:
- Two back-to-back inputs with out_ready=0 for 3 cycles -> in_ready=0 once full, result held stable, both results delivered in order with no loss or duplication.
- rst asserted with both stages full -> out_valid=0 the next cycle, and no stale output appears.

Source files
------------

// File: rtl/fp_mul_norm_round_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fp_mul_norm_round_pkg
// Description : Shared constants and types for the FP multiplier
//               normalize/round back end.
// Revision    : 1.0 - initial release
// ============================================================================
package fp_mul_norm_round_pkg;

    // IEEE-754 single-precision exponent constants
    localparam int c_bias    = 127;
    localparam int c_exp_max = 255;

    // Canonical quiet NaN
    localparam logic [31:0] c_qnan = 32'h7FC0_0000;

    // Bit positions inside spec_in = {is_nan, is_inf, is_zero}
    localparam int c_spec_nan  = 2;
    localparam int c_spec_inf  = 1;
    localparam int c_spec_zero = 0;

    // Bit positions inside flags = {overflow, underflow, inexact}
    localparam int c_flag_ovf = 2;
    localparam int c_flag_unf = 1;
    localparam int c_flag_inx = 0;

    // Working exponent width: 10-bit signed input plus one bit of headroom
    localparam int c_exp_w = 11;

    // Contents of the normalize stage register
    typedef struct packed {
        logic                       sign;
        logic [2:0]                 spec;
        logic signed [c_exp_w-1:0]  exp;
        logic [22:0]                mant;
        logic                       guard;
        logic                       sticky;
    } s1_t;

endpackage : fp_mul_norm_round_pkg
`default_nettype wire

// File: rtl/fp_mul_norm_round_if.sv
`default_nettype none
// ============================================================================
// Module      : fp_mul_norm_round_if
// Description : Valid/ready input and output channels of the normalize/round
//               back end.
// Revision    : 1.0 - initial release
// ============================================================================
interface fp_mul_norm_round_if;

    // Input channel
    logic        in_valid;
    logic        in_ready;
    logic [47:0] prod;
    logic [9:0]  exp_sum;
    logic        sign_in;
    logic [2:0]  spec_in;

    // Output channel
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic [2:0]  flags;

    // Upstream producer / downstream consumer side
    modport master (
        output in_valid, prod, exp_sum, sign_in, spec_in, out_ready,
        input  in_ready, out_valid, result, flags
    );

    // The rounding block itself
    modport slave (
        input  in_valid, prod, exp_sum, sign_in, spec_in, out_ready,
        output in_ready, out_valid, result, flags
    );

endinterface : fp_mul_norm_round_if
`default_nettype wire

// File: rtl/fp_mul_norm_round_rne.sv
`default_nettype none
// ============================================================================
// Module      : fp_round_rne
// Description : Combinational round-to-nearest-even, exponent limit handling,
//               special-operand override and IEEE-754 single packing.
// Revision    : 1.0 - initial release
// ============================================================================
module fp_round_rne
    import fp_mul_norm_round_pkg::*;
#(
    parameter int FLUSH_SUBNORMAL = 1
) (
    input  wire logic [22:0]                i_mant,
    input  wire logic                       i_guard,
    input  wire logic                       i_sticky,
    input  wire logic signed [c_exp_w-1:0]  i_exp,
    input  wire logic                       i_sign,
    input  wire logic [2:0]                 i_spec,
    output logic [31:0]                     o_result,
    output logic [2:0]                      o_flags
);

    logic                       w_inc;
    logic [23:0]                w_mant_sum;
    logic signed [c_exp_w-1:0]  w_exp_f;
    logic                       w_inexact;
    logic [30:0]                w_uf_mag;
    logic                       w_uf_inexact;

    // Round-to-nearest-even on the normal path; a carry-out bumps the exponent
    always_comb begin
        w_inc      = i_guard && (i_sticky || i_mant[0]);
        w_mant_sum = {1'b0, i_mant} + {23'd0, w_inc};
        w_exp_f    = i_exp + $signed({{(c_exp_w-1){1'b0}}, w_mant_sum[23]});
        w_inexact  = i_guard || i_sticky;
    end

    generate
        if (FLUSH_SUBNORMAL != 0) begin : g_flush
            // Tiny results collapse to signed zero and always lose precision
            assign w_uf_mag     = 31'd0;
            assign w_uf_inexact = 1'b1;
        end else begin : g_denorm
            logic signed [c_exp_w-1:0] w_sh_full;
            logic [4:0]                w_sh;
            logic [49:0]               w_ext;
            logic                      w_dg;
            logic                      w_ds;
            logic                      w_dinc;

            // Denormalize by (1 - exp), then round the shifted significand
            always_comb begin
                w_sh_full = $signed(11'sd1) - i_exp;
                if (w_sh_full > $signed(11'sd26)) begin
                    w_sh = 5'd26;
                end else if (w_sh_full < $signed(11'sd1)) begin
                    w_sh = 5'd0;
                end else begin
                    w_sh = w_sh_full[4:0];
                end
                w_ext        = {1'b1, i_mant, i_guard, 25'd0} >> w_sh;
                w_dg         = w_ext[25];
                w_ds         = (|w_ext[24:0]) || i_sticky;
                w_dinc       = w_dg && (w_ds || w_ext[26]);
                w_uf_mag     = {7'd0, w_ext[49:26]} + {30'd0, w_dinc};
                w_uf_inexact = w_dg || w_ds;
            end
        end
    endgenerate

    // Special operands first, then overflow, underflow and normal packing
    always_comb begin
        o_result = 32'd0;
        o_flags  = 3'd0;
        if (i_spec[c_spec_nan] || (i_spec[c_spec_inf] && i_spec[c_spec_zero])) begin
            o_result = c_qnan;
        end else if (i_spec[c_spec_inf]) begin
            o_result = {i_sign, 8'hFF, 23'd0};
        end else if (i_spec[c_spec_zero]) begin
            o_result = {i_sign, 31'd0};
        end else if (w_exp_f >= $signed(c_exp_w'(c_exp_max))) begin
            o_result             = {i_sign, 8'hFF, 23'd0};
            o_flags[c_flag_ovf]  = 1'b1;
            o_flags[c_flag_inx]  = 1'b1;
        end else if (w_exp_f <= $signed(11'sd0)) begin
            o_result             = {i_sign, w_uf_mag};
            o_flags[c_flag_unf]  = w_uf_inexact;
            o_flags[c_flag_inx]  = w_uf_inexact;
        end else begin
            o_result             = {i_sign, w_exp_f[7:0], w_mant_sum[22:0]};
            o_flags[c_flag_inx]  = w_inexact;
        end
    end

endmodule : fp_round_rne
`default_nettype wire

// File: rtl/fp_mul_norm_round.sv
`default_nettype none
// ============================================================================
// Module      : fp_mul_norm_round
// Description : Two-stage normalize / round-and-pack back end for a single
//               precision multiplier, with valid/ready flow control.
// Revision    : 1.0 - initial release
// ============================================================================
module fp_mul_norm_round
    import fp_mul_norm_round_pkg::*;
#(
    parameter int FLUSH_SUBNORMAL = 1
) (
    input  wire logic           clk,
    input  wire logic           rst,
    fp_mul_norm_round_if.slave  bus
);

    logic        w_advance;
    s1_t         w_norm;
    logic [31:0] w_rnd_result;
    logic [2:0]  w_rnd_flags;

    logic        r_s1_valid;
    s1_t         r_s1;
    logic        r_out_valid;
    logic [31:0] r_result;
    logic [2:0]  r_flags;

    // Both stages move together whenever the output slot is free or draining
    assign w_advance     = !r_out_valid || bus.out_ready;
    assign bus.in_ready  = w_advance;
    assign bus.out_valid = r_out_valid;
    assign bus.result    = r_result;
    assign bus.flags     = r_flags;

    // Normalize: the leading one sits at bit 47 or bit 46 of the product
    always_comb begin
        w_norm      = '0;
        w_norm.sign = bus.sign_in;
        w_norm.spec = bus.spec_in;
        if (bus.prod[47]) begin
            w_norm.mant   = bus.prod[46:24];
            w_norm.guard  = bus.prod[23];
            w_norm.sticky = |bus.prod[22:0];
            w_norm.exp    = {bus.exp_sum[9], bus.exp_sum} + 11'd1;
        end else begin
            w_norm.mant   = bus.prod[45:23];
            w_norm.guard  = bus.prod[22];
            w_norm.sticky = |bus.prod[21:0];
            w_norm.exp    = {bus.exp_sum[9], bus.exp_sum};
        end
    end

    fp_round_rne #(
        .FLUSH_SUBNORMAL (FLUSH_SUBNORMAL)
    ) u_round (
        .i_mant   (r_s1.mant),
        .i_guard  (r_s1.guard),
        .i_sticky (r_s1.sticky),
        .i_exp    (r_s1.exp),
        .i_sign   (r_s1.sign),
        .i_spec   (r_s1.spec),
        .o_result (w_rnd_result),
        .o_flags  (w_rnd_flags)
    );

    // Pipeline registers: payloads load only behind a valid bit, all hold on stall
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid  <= 1'b0;
            r_s1        <= '0;
            r_out_valid <= 1'b0;
            r_result    <= 32'd0;
            r_flags     <= 3'd0;
        end else if (w_advance) begin
            r_s1_valid  <= bus.in_valid;
            if (bus.in_valid) begin
                r_s1 <= w_norm;
            end
            r_out_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_result <= w_rnd_result;
                r_flags  <= w_rnd_flags;
            end
        end
    end

endmodule : fp_mul_norm_round
`default_nettype wire
